// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter register and instruction-fetch request sequencer.
// The PC advances using an externally computed pc + 4 (no adder in here),
// redirects on jump / taken branch, holds on stall, and traps on any
// misaligned next-PC until reset.
//
// Ports
//   clk               in   clock, all state updates on rising edge
//   rst_n             in   asynchronous active-low reset
//   pc_plus4_i        in   pc_o + 4 from the downstream adder
//   jump_i            in   jump redirect request
//   jump_target_i     in   jump destination
//   branch_taken_i    in   taken-branch redirect request
//   branch_target_i   in   branch destination
//   stall_i           in   hold PC advance
//   imem_req_ready_i  in   instruction memory accepts the request
//   imem_req_valid_o  out  fetch request valid (FETCH state only)
//   imem_addr_o       out  fetch address, always equal to pc_o
//   pc_o              out  current PC
//   misaligned_o      out  sticky misaligned-target trap flag
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_plus4_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             stall_i,
    input  logic             imem_req_ready_i,
    output logic             imem_req_valid_o,
    output logic [WIDTH-1:0] imem_addr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic             misaligned_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pend_target;
    logic             pend_vld;
    logic             req_vld;
    logic             mis;

    logic             accept;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] next_pc;
    logic             next_ok;

    function automatic logic is_aligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Next-PC selection: a fresh redirect this cycle beats a redirect that
    // arrived while the previous request was still waiting for ready.
    always_comb begin
        accept          = req_vld & imem_req_ready_i;
        redirect        = jump_i | branch_taken_i;
        redirect_target = jump_i ? jump_target_i : branch_target_i;
        if (redirect)
            next_pc = redirect_target;
        else if (pend_vld)
            next_pc = pend_target;
        else
            next_pc = pc_plus4_i;
        next_ok = is_aligned(next_pc);
    end

    // Pending redirect target is plain data; pend_vld qualifies it.
    always_ff @(posedge clk) begin
        if (state == FETCH && !accept && redirect)
            pend_target <= redirect_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            pend_vld <= 1'b0;
            req_vld  <= 1'b0;
            mis      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= stall_i ? HOLD : FETCH;
                    req_vld <= !stall_i;
                end

                FETCH: begin
                    if (accept) begin
                        if (!next_ok) begin
                            state    <= TRAP;
                            req_vld  <= 1'b0;
                            mis      <= 1'b1;
                            pend_vld <= 1'b0;
                        end else begin
                            pc       <= next_pc;
                            pend_vld <= 1'b0;
                            state    <= stall_i ? HOLD : FETCH;
                            req_vld  <= !stall_i;
                        end
                    end else if (redirect) begin
                        // Request stays on the bus unchanged; remember where
                        // to go once it is finally accepted.
                        pend_vld <= 1'b1;
                    end
                end

                HOLD: begin
                    if ((redirect || pend_vld) && !next_ok) begin
                        state    <= TRAP;
                        req_vld  <= 1'b0;
                        mis      <= 1'b1;
                        pend_vld <= 1'b0;
                    end else begin
                        // Without a redirect the PC simply holds; pc_plus4_i
                        // is deliberately ignored here.
                        if (redirect || pend_vld) begin
                            pc       <= next_pc;
                            pend_vld <= 1'b0;
                        end
                        state   <= stall_i ? HOLD : FETCH;
                        req_vld <= !stall_i;
                    end
                end

                default: begin
                    // TRAP: frozen until reset.
                    state   <= TRAP;
                    req_vld <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid_o = req_vld;
    assign imem_addr_o      = pc;
    assign pc_o             = pc;
    assign misaligned_o     = mis;

endmodule
